// File: rtl/serial_cascade_comparator_pkg.sv
// cmp_pkg: state encoding, digit width and cascade reset constants for the serial comparator.
package cmp_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
   localparam int DIG_W = 2;
   localparam logic G0 = 1'b0;
   localparam logic E0 = 1'b1;
   localparam logic L0 = 1'b0;
endpackage

// File: rtl/serial_cascade_comparator_if.sv
// serial_cascade_comparator_if: start/done handshake, operands and G/E/L result bundle.
interface serial_cascade_comparator_if #(parameter int WIDTH = 8);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             gt;
   logic             eq;
   logic             lt;
   modport master (output start, a, b, input busy, done, gt, eq, lt);
   modport slave  (input start, a, b, output busy, done, gt, eq, lt);
endinterface

// File: rtl/serial_cascade_comparator_slice.sv
// cmp2_slice: combinational 2-bit magnitude slice; compares its digit only while the cascade is still equal.
module cmp2_slice
   import cmp_pkg::*;
(
   input  logic [DIG_W-1:0] a_d,
   input  logic [DIG_W-1:0] b_d,
   input  logic             gi,
   input  logic             ei,
   input  logic             li,
   output logic             go,
   output logic             eo,
   output logic             lo
);
   assign go = ei ? (a_d > b_d) : gi;
   assign eo = ei ? (a_d == b_d) : 1'b0;
   assign lo = ei ? (a_d < b_d) : li;
endmodule

// File: rtl/serial_cascade_comparator.sv
// serial_cascade_comparator: WIDTH-bit compare, one 2-bit digit per cycle MSB first, start/done handshake.
// Optional macro EARLY_EXIT_EN: finish as soon as the cascade leaves the equal state.
module serial_cascade_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic                     clk,
   input logic                     rst,
   serial_cascade_comparator_if.slave bus
);
   localparam int NDIG = WIDTH / DIG_W;
   localparam int CW   = NDIG > 1 ? $clog2(NDIG) : 1;
   state_t state, state_nx;
   logic [WIDTH-1:0] sa, sb;
   logic [CW-1:0] cnt;
   logic cg, ce, cl, go, eo, lo, gt, eq, lt, load, last;
   cmp2_slice u_slice (
      .a_d(sa[WIDTH-1 -: DIG_W]),
      .b_d(sb[WIDTH-1 -: DIG_W]),
      .gi(cg), .ei(ce), .li(cl),
      .go(go), .eo(eo), .lo(lo)
   );
`ifdef EARLY_EXIT_EN
   assign last = (cnt == '0) || !eo;
`else
   assign last = (cnt == '0);
`endif
   assign load = bus.start && (state != RUN);
   always_comb begin
      state_nx = state;
      state_nx = (state == RUN) ? (last ? DONE : RUN) : (bus.start ? RUN : IDLE);
   end
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sa  <= '0;
         sb  <= '0;
         cnt <= '0;
         cg  <= G0;
         ce  <= E0;
         cl  <= L0;
         gt  <= 1'b0;
         eq  <= 1'b0;
         lt  <= 1'b0;
      end else if (load) begin
         sa  <= bus.a;
         sb  <= bus.b;
         cnt <= CW'(NDIG - 1);
         cg  <= G0;
         ce  <= E0;
         cl  <= L0;
      end else if (state == RUN) begin
         sa  <= sa << DIG_W;
         sb  <= sb << DIG_W;
         cnt <= cnt - 1'b1;
         cg  <= go;
         ce  <= eo;
         cl  <= lo;
         // Result registers load only on the transition into DONE
         if (last) begin
            gt <= go;
            eq <= eo;
            lt <= lo;
         end
      end
   end
   assign bus.busy = (state == RUN);
   assign bus.done = (state == DONE);
   assign bus.gt   = gt;
   assign bus.eq   = eq;
   assign bus.lt   = lt;
endmodule

// File: tb/tb_serial_cascade_comparator.sv
// tb_serial_cascade_comparator: vector table plus handshake corner sequences, scoreboard-checked on done.
module tb_serial_cascade_comparator;
   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] gel;
   } vec_t;
   typedef struct {
      logic [2:0] gel;
      int         due;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   exp_t q[$];
   vec_t tbl[10];
   serial_cascade_comparator_if #(.WIDTH(8)) bus ();
   serial_cascade_comparator #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   function automatic int lat(input logic [7:0] a, input logic [7:0] b);
`ifdef EARLY_EXIT_EN
      for (int k = 1; k <= 4; k++)
         if (a[9-2*k -: 2] != b[9-2*k -: 2]) return k + 1;
`endif
      return 5;
   endfunction
   function automatic logic [2:0] model(input logic [7:0] a, input logic [7:0] b);
      return {a > b, a == b, a < b};
   endfunction
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending compare (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("result_gel", {bus.gt, bus.eq, bus.lt}, e.gel);
            chk("done_cycle", cyc, e.due);
            chk("onehot", $countones({bus.gt, bus.eq, bus.lt}), 1);
         end
      end
   end
   task automatic drain(input string name);
      int n;
      n = 0;
      while (q.size() != 0 && n < 40) begin
         @(posedge clk);
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got %0d pending expected 0", name, q.size());
         q.delete();
      end
   endtask
   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] gel, input int l);
      exp_t e;
      bus.start = 1'b1;
      bus.a = a;
      bus.b = b;
      e.gel = gel;
      e.due = cyc + l;
      q.push_back(e);
   endtask
   initial begin
      int t;
      tbl[0] = '{8'hA5, 8'hA5, 3'b010};
      tbl[1] = '{8'h80, 8'h7F, 3'b100};
      tbl[2] = '{8'h12, 8'h13, 3'b001};
      tbl[3] = '{8'h00, 8'h00, 3'b010};
      tbl[4] = '{8'hFF, 8'h00, 3'b100};
      tbl[5] = '{8'h00, 8'hFF, 3'b001};
      tbl[6] = '{8'hFF, 8'hFF, 3'b010};
      tbl[7] = '{8'h3C, 8'h3D, 3'b001};
      tbl[8] = '{8'h7F, 8'h80, 3'b001};
      tbl[9] = '{8'hC0, 8'hBF, 3'b100};
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", bus.busy, 0);
      chk("reset_done", bus.done, 0);
      chk("reset_gel", {bus.gt, bus.eq, bus.lt}, 0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         issue(tbl[i].a, tbl[i].b, tbl[i].gel, lat(tbl[i].a, tbl[i].b));
         @(negedge clk);
         bus.start = 1'b0;
         chk("busy_after_accept", bus.busy, 1);
         drain("table");
         @(negedge clk);
         chk("idle_after_done", bus.busy | bus.done, 0);
      end
      // start pulsed mid-RUN must not reload or queue
      @(negedge clk);
      t = cyc;
      issue(8'h12, 8'h13, 3'b001, 5);
      @(negedge clk);
      bus.start = 1'b0;
      bus.a = 8'hFF;
      bus.b = 8'h00;
      @(negedge clk);
      chk("busy_mid_run", bus.busy, 1);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      drain("ignore");
      repeat (8) @(negedge clk);
      // start held high: back-to-back compares with no idle cycle
      t = cyc;
      issue(8'h12, 8'h13, 3'b001, 5);
      @(negedge clk);
      issue(8'hA5, 8'hA5, 3'b010, 9);
      repeat (5) @(negedge clk);
      issue(8'h13, 8'h12, 3'b100, 9);
      repeat (5) @(negedge clk);
      bus.start = 1'b0;
      drain("b2b");
      repeat (3) @(negedge clk);
      chk("b2b_end_cycle_span", cyc - t >= 15 ? 1 : 0, 1);
      // reset in the middle of RUN clears everything and drops the compare
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = 8'h12;
      bus.b = 8'h13;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_gel", {bus.gt, bus.eq, bus.lt}, 0);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      chk("rst_idle", bus.busy | bus.done, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
